// File: rtl/io_spi_arbiter.sv
// io_spi_arbiter: round-robin owner selection for one shared SPI shift engine.
// Each requester holds a level request until its done pulse; the winner's tx
// word is presented to io_spi, the received word is returned, and only the
// winner's device sees the engine's chip select. A stuck transfer is aborted
// after TIMEOUT cycles in WAIT and reported through err alongside done.
module io_spi_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       err,
  output logic [WIDTH-1:0]         rx_data,
  output logic                     busy,
  output logic                     spi_start,
  input  logic                     spi_done,
  output logic [WIDTH-1:0]         spi_tx_data,
  input  logic [WIDTH-1:0]         spi_rx_data,
  input  logic                     spi_cs_in,
  output logic [NUM_REQ-1:0]       cs_n
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    ARB     = 5'b00010,
    START   = 5'b00100,
    WAIT    = 5'b01000,
    RELEASE = 5'b10000
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   tx_q, tx_d;
  logic [WIDTH-1:0]   rx_q, rx_d;

  logic               pick_valid;
  logic [PW-1:0]      pick_idx;

  // Round-robin search: first asserted request at or above ptr, wrapping.
  always_comb begin
    int unsigned idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  // Next-state and datapath updates for the grant/transfer sequence.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          tx_d              = req_data[pick_idx*WIDTH +: WIDTH];
          state_d           = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completing transfer takes precedence over an expiring counter.
        if (spi_done) begin
          rx_d    = spi_rx_data;
          state_d = RELEASE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  // Handshake outputs decode registered state only; no path from req.
  assign busy        = (state_q != IDLE);
  assign spi_start   = (state_q == START);
  assign grant       = grant_q;
  assign done        = (state_q == RELEASE) ? grant_q : '0;
  assign err         = (state_q == RELEASE && err_q) ? grant_q : '0;
  assign spi_tx_data = tx_q;
  assign rx_data     = rx_q;

  // Only the owner's device sees the engine's chip select.
  assign cs_n = ~grant_q | {NUM_REQ{spi_cs_in}};

endmodule

// File: tb/tb_io_spi_arbiter.sv
module tb_io_spi_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 16;

  localparam logic [W-1:0] S0 = 32'h1111_0000;
  localparam logic [W-1:0] S1 = 32'h683C_0250;
  localparam logic [W-1:0] S2 = 32'h2222_0002;
  localparam logic [W-1:0] S3 = 32'h3333_0003;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant, done, err, cs_n;
  logic [W-1:0]   rx_data, spi_tx_data, spi_rx_data;
  logic           busy, spi_start, spi_done, spi_cs_in;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  io_spi_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .rx_data(rx_data), .busy(busy),
    .spi_start(spi_start), .spi_done(spi_done), .spi_tx_data(spi_tx_data),
    .spi_rx_data(spi_rx_data), .spi_cs_in(spi_cs_in), .cs_n(cs_n)
  );

  // Response the stand-in SPI device returns for a given transmit word.
  function automatic logic [W-1:0] resp(input logic [W-1:0] t);
    return {t[15:0], t[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in io_spi: answers spi_start after a 5-cycle transfer unless hung.
  int            sl_cnt = 0;
  logic [W-1:0]  sl_rx;
  bit            hang = 1'b0;
  initial begin
    spi_done = 1'b0; spi_cs_in = 1'b1; spi_rx_data = '0; sl_rx = '0;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        sl_cnt = 0; spi_cs_in = 1'b1;
      end else if (spi_start) begin
        spi_cs_in = 1'b0; sl_cnt = 5; sl_rx = resp(spi_tx_data);
      end else if (sl_cnt > 0) begin
        sl_cnt--;
        if (sl_cnt == 0) begin
          spi_cs_in = 1'b1;
          if (!hang) begin spi_done = 1'b1; spi_rx_data = sl_rx; end
        end
      end
    end
  end

  // Reference model: a transaction tracked by its age in cycles since the
  // request was accepted; m_end is the age at which it is released.
  int           m_age, m_end, m_owner, m_ptr;
  bit           m_have, m_err;
  logic [W-1:0] m_tx, m_rx;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= 0; m_end <= 0; m_owner <= 0; m_ptr <= 0;
      m_have <= 1'b0; m_err <= 1'b0; m_tx <= '0; m_rx <= '0;
    end else if (m_age == 0) begin
      if (|req) m_age <= 1;
    end else if (m_age == 1) begin
      if (rr_pick(req, m_ptr) < 0) m_age <= 0;
      else begin
        m_owner <= rr_pick(req, m_ptr);
        m_tx    <= req_data[rr_pick(req, m_ptr)*W +: W];
        m_have  <= 1'b1; m_end <= 0; m_age <= 2;
      end
    end else if (m_age == m_end) begin
      m_age <= 0; m_end <= 0; m_have <= 1'b0; m_err <= 1'b0;
      m_ptr <= (m_owner + 1) % N;
    end else begin
      if (m_age >= 3) begin
        if (spi_done) begin m_end <= m_age + 1; m_rx <= spi_rx_data; end
        else if (m_age - 2 == TMO) begin m_end <= m_age + 1; m_err <= 1'b1; end
      end
      m_age <= m_age + 1;
    end
  end

  function automatic logic [N-1:0] e_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_have && m_age >= 2) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [N-1:0] e_done();
    return (m_age != 0 && m_age == m_end) ? e_grant() : '0;
  endfunction

  function automatic logic [N-1:0] e_cs();
    logic [N-1:0] c;
    c = '1;
    for (int i = 0; i < N; i++) if (e_grant()[i]) c[i] = spi_cs_in;
    return c;
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("grant", grant, e_grant());
    chk("done", done, e_done());
    chk("err", err, m_err ? e_done() : '0);
    chk("busy", busy, m_age != 0);
    chk("spi_start", spi_start, m_age == 2);
    chk("spi_tx_data", spi_tx_data, m_tx);
    chk("rx_data", rx_data, m_rx);
    chk("cs_n", cs_n, e_cs());
  end

  // Observation counters for the directed checks.
  int           n_start = 0;
  int           wait_cycles = 0;
  logic [W-1:0] last_tx = '0;
  bit           nonowner_low = 1'b0;
  initial forever begin
    @(negedge clk);
    if (spi_start) begin n_start++; last_tx = spi_tx_data; wait_cycles = 0; end
    else if (grant != 0 && done == 0) wait_cycles++;
    for (int i = 0; i < N; i++) if (!cs_n[i] && !grant[i]) nonowner_low = 1'b1;
  end

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_done(output logic [N-1:0] d, output logic [N-1:0] e);
    d = '0; e = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done != 0) begin d = done; e = err; return; end
    end
    chk("done_wait_bound", 0, 1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_wait_bound", 0, 1);
  endtask

  task automatic set_req(input logic [N-1:0] r);
    @(posedge clk); #1 req = r;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [N-1:0] d, e;
  int           log_q[$];
  int           exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    req = '0;
    req_data = {S3, S2, S1, S0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_rx", rx_data, 0);

    // Single request from requester 1.
    n_start = 0; nonowner_low = 1'b0;
    set_req(4'b0010);
    wait_done(d, e);
    chk("t1_done", d, 4'b0010);
    chk("t1_err", e, 0);
    chk("t1_rx", rx_data, 32'h580A_CD99);
    set_req(4'b0000);
    wait_idle();
    chk("t1_starts", n_start, 1);
    chk("t1_tx", last_tx, 32'h683C_0250);
    chk("t1_cs_isolation", nonowner_low, 0);

    // All four held from reset: order 0,1,2,3,0.
    do_reset();
    n_start = 0; log_q.delete();
    set_req(4'b1111);
    for (int k = 0; k < 5; k++) begin
      wait_done(d, e);
      log_q.push_back(idx_of(d));
    end
    set_req(4'b0000);
    wait_idle();
    chk("t2_count", log_q.size(), 5);
    for (int k = 0; k < 5 && k < log_q.size(); k++) chk("t2_order", log_q[k], exp_order[k]);
    chk("t2_starts", n_start, 5);

    // Fairness: after requester 2 completes, 3 beats 0.
    set_req(4'b0100);
    wait_done(d, e);
    chk("t3_first", d, 4'b0100);
    set_req(4'b0000);
    wait_idle();
    log_q.delete();
    set_req(4'b1001);
    for (int k = 0; k < 2; k++) begin
      wait_done(d, e);
      log_q.push_back(idx_of(d));
      set_req(req & ~d);
    end
    wait_idle();
    chk("t3_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t3_order0", log_q[0], 3);
      chk("t3_order1", log_q[1], 0);
    end

    // Timeout with no spi_done.
    hang = 1'b1;
    set_req(4'b0001);
    wait_done(d, e);
    chk("t4_done", d, 4'b0001);
    chk("t4_err", e, 4'b0001);
    chk("t4_rx_kept", rx_data, resp(S0));
    chk("t4_wait_cycles", wait_cycles, TMO);
    set_req(4'b0000);
    @(negedge clk);
    chk("t4_busy_fall", busy, 0);
    hang = 1'b0;
    wait_idle();

    // Reset mid-WAIT while requester 2 owns the engine.
    hang = 1'b1;
    set_req(4'b0100);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (grant == 4'b0100 && !spi_start) break;
    end
    chk("t5_grant_before", grant, 4'b0100);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_cs_n", cs_n, 4'hF);
    chk("t5_rx", rx_data, 0);
    chk("t5_tx", spi_tx_data, 0);
    req = '0; hang = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Two requesters expose the pointer: a cleared pointer serves 0 first.
    log_q.delete();
    set_req(4'b0011);
    for (int k = 0; k < 2; k++) begin
      wait_done(d, e);
      log_q.push_back(idx_of(d));
      set_req(req & ~d);
    end
    wait_idle();
    chk("t5_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t5_order0", log_q[0], 0);
      chk("t5_order1", log_q[1], 1);
    end

    // Request withdrawn before ARB.
    n_start = 0; log_q.delete();
    set_req(4'b1000);
    set_req(4'b0000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done != 0) log_q.push_back(idx_of(done));
    end
    chk("t6_starts", n_start, 0);
    chk("t6_dones", log_q.size(), 0);
    chk("t6_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
